gs232c_check_pc_pipe: RTL and testbench

- Pipelined, multi-channel successor of the single-slot combinational next-PC checker.
- Each cycle accepts one bundle of up to NCH branch slots. Per slot it checks whether the predicted next PC equals base+offs, and computes the low-part target plus carry.
- Locates the oldest mispredicted slot and presents a redirect request downstream over a valid/ready handshake.
- Sits between branch-execute operand read and the frontend redirect logic.

---
 rtl/gs232c_check_pc_pipe.sv | 180 ++++++++++++++++++
 tb/tb_gs232c_check_pc_pipe.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/gs232c_check_pc_pipe.sv
// Two-stage multi-slot next-PC checker: registers a bundle of branch slots, verifies
// each predicted next PC against base+offs and reports the oldest mispredicted slot.
module gs232c_check_pc_pipe #(
    parameter int LO_W  = 26,
    parameter int NCH   = 2,
    parameter int IDX_W = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NCH-1:0]        in_slot_vld,
    input  logic [NCH*LO_W-1:0]   in_next,
    input  logic [NCH*LO_W-1:0]   in_base,
    input  logic [NCH*LO_W-1:0]   in_offs,
    input  logic [NCH-1:0]        in_same_b,
    input  logic [NCH-1:0]        in_same_c,
    input  logic [NCH-1:0]        in_same_h,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NCH-1:0]        out_same,
    output logic                  out_miss,
    output logic [IDX_W-1:0]      out_miss_idx,
    output logic [LO_W-1:0]       out_target,
    output logic                  out_carry
);

    logic                s1_valid_r;
    logic [NCH-1:0]      s1_slot_vld_r;
    logic [NCH*LO_W-1:0] s1_next_r;
    logic [NCH*LO_W-1:0] s1_base_r;
    logic [NCH*LO_W-1:0] s1_offs_r;
    logic [NCH-1:0]      s1_same_b_r;
    logic [NCH-1:0]      s1_same_c_r;
    logic [NCH-1:0]      s1_same_h_r;

    logic                s2_valid_r;
    logic [NCH-1:0]      s2_same_r;
    logic                s2_miss_r;
    logic [IDX_W-1:0]    s2_miss_idx_r;
    logic [LO_W-1:0]     s2_target_r;
    logic                s2_carry_r;

    logic                s2_adv_s;
    logic                in_ready_s;
    logic [NCH-1:0]      same_s;
    logic [NCH-1:0]      carry_s;
    logic [LO_W-1:0]     tgt_s [NCH];
    logic [NCH-1:0]      miss_vec_s;
    logic                miss_s;
    logic [IDX_W-1:0]    miss_idx_s;
    logic [LO_W-1:0]     sel_tgt_s;
    logic                sel_carry_s;

    assign s2_adv_s   = !s2_valid_r || out_ready;
    assign in_ready_s = !flush && (!s1_valid_r || s2_adv_s);
    assign in_ready   = in_ready_s;

    for (genvar g = 0; g < NCH; g++) begin : g_slot
        logic [LO_W-1:0] base_s;
        logic [LO_W-1:0] offs_s;
        logic [LO_W-1:0] next_s;
        logic [LO_W:0]   sum_s;
        logic [LO_W-1:0] cs_x_s;
        logic [LO_W-1:0] cs_c_s;
        logic            eq_s;
        logic            cs_carry_s;
        logic            hi_ok_s;

        assign base_s = s1_base_r[g*LO_W +: LO_W];
        assign offs_s = s1_offs_r[g*LO_W +: LO_W];
        assign next_s = s1_next_r[g*LO_W +: LO_W];
        assign sum_s  = {1'b0, base_s} + {1'b0, offs_s};

        // base+offs==next iff every bit's implied carry-in matches the carry it generates,
        // so the compare and its carry-out need no carry propagation.
        assign cs_x_s     = base_s ^ offs_s ^ next_s;
        assign cs_c_s     = (base_s & offs_s) | ((base_s ^ offs_s) & ~next_s);
        assign eq_s       = (cs_x_s == {cs_c_s[LO_W-2:0], 1'b0});
        assign cs_carry_s = cs_c_s[LO_W-1];

        // Pick which high-part prediction must hold given the low-part carry and offset sign.
        always_comb begin
            hi_ok_s = 1'b0;
            if (cs_carry_s == offs_s[LO_W-1]) begin
                hi_ok_s = s1_same_h_r[g];
            end else if (offs_s[LO_W-1]) begin
                hi_ok_s = s1_same_b_r[g];
            end else begin
                hi_ok_s = s1_same_c_r[g];
            end
        end

        assign same_s[g]  = s1_slot_vld_r[g] & eq_s & hi_ok_s;
        assign tgt_s[g]   = sum_s[LO_W-1:0];
        assign carry_s[g] = sum_s[LO_W];
    end

    // Lowest-index mismatching slot wins; with no miss the select stays on slot 0.
    always_comb begin
        miss_vec_s = ~same_s & s1_slot_vld_r;
        miss_s     = |miss_vec_s;
        miss_idx_s = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            miss_idx_s = miss_vec_s[i] ? IDX_W'(i) : miss_idx_s;
        end
        sel_tgt_s   = tgt_s[miss_idx_s];
        sel_carry_s = carry_s[miss_idx_s];
    end

    // Stage 1: capture an accepted bundle; empties when it moves on with nothing behind it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid_r    <= 1'b0;
            s1_slot_vld_r <= '0;
            s1_next_r     <= '0;
            s1_base_r     <= '0;
            s1_offs_r     <= '0;
            s1_same_b_r   <= '0;
            s1_same_c_r   <= '0;
            s1_same_h_r   <= '0;
        end else if (flush) begin
            s1_valid_r <= 1'b0;
        end else if (in_ready_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_slot_vld_r <= in_slot_vld;
                s1_next_r     <= in_next;
                s1_base_r     <= in_base;
                s1_offs_r     <= in_offs;
                s1_same_b_r   <= in_same_b;
                s1_same_c_r   <= in_same_c;
                s1_same_h_r   <= in_same_h;
            end
        end
    end

    // Stage 2: result register; data is zeroed whenever the stage holds no bundle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s2_valid_r    <= 1'b0;
            s2_same_r     <= '0;
            s2_miss_r     <= 1'b0;
            s2_miss_idx_r <= '0;
            s2_target_r   <= '0;
            s2_carry_r    <= 1'b0;
        end else if (flush) begin
            s2_valid_r    <= 1'b0;
            s2_same_r     <= '0;
            s2_miss_r     <= 1'b0;
            s2_miss_idx_r <= '0;
            s2_target_r   <= '0;
            s2_carry_r    <= 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_same_r     <= same_s;
                s2_miss_r     <= miss_s;
                s2_miss_idx_r <= miss_idx_s;
                s2_target_r   <= sel_tgt_s;
                s2_carry_r    <= sel_carry_s;
            end else begin
                s2_same_r     <= '0;
                s2_miss_r     <= 1'b0;
                s2_miss_idx_r <= '0;
                s2_target_r   <= '0;
                s2_carry_r    <= 1'b0;
            end
        end
    end

    assign out_valid    = s2_valid_r;
    assign out_same     = s2_same_r;
    assign out_miss     = s2_miss_r;
    assign out_miss_idx = s2_miss_idx_r;
    assign out_target   = s2_target_r;
    assign out_carry    = s2_carry_r;

endmodule

// File: tb/tb_gs232c_check_pc_pipe.sv
// Directed bench for gs232c_check_pc_pipe: vector table for the arithmetic plus
// hand sequences for backpressure, flush and reset.
module tb_gs232c_check_pc_pipe;

    localparam int LO_W  = 26;
    localparam int NCH   = 2;
    localparam int IDX_W = 1;

    logic                clk;
    logic                resetn;
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [NCH-1:0]      in_slot_vld;
    logic [NCH*LO_W-1:0] in_next;
    logic [NCH*LO_W-1:0] in_base;
    logic [NCH*LO_W-1:0] in_offs;
    logic [NCH-1:0]      in_same_b;
    logic [NCH-1:0]      in_same_c;
    logic [NCH-1:0]      in_same_h;
    logic                out_valid;
    logic                out_ready;
    logic [NCH-1:0]      out_same;
    logic                out_miss;
    logic [IDX_W-1:0]    out_miss_idx;
    logic [LO_W-1:0]     out_target;
    logic                out_carry;

    gs232c_check_pc_pipe #(.LO_W(LO_W), .NCH(NCH), .IDX_W(IDX_W)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_slot_vld(in_slot_vld),
        .in_next(in_next), .in_base(in_base), .in_offs(in_offs),
        .in_same_b(in_same_b), .in_same_c(in_same_c), .in_same_h(in_same_h),
        .out_valid(out_valid), .out_ready(out_ready), .out_same(out_same),
        .out_miss(out_miss), .out_miss_idx(out_miss_idx),
        .out_target(out_target), .out_carry(out_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  vld;
        logic [25:0] nx0, bs0, of0, nx1, bs1, of1;
        logic [1:0]  sb, sc, sh;
        logic [1:0]  e_same;
        logic        e_miss;
        logic        e_idx;
        logic [25:0] e_tgt;
        logic        e_carry;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_vec(input vec_t v);
        in_slot_vld = v.vld;
        in_next     = {v.nx1, v.nx0};
        in_base     = {v.bs1, v.bs0};
        in_offs     = {v.of1, v.of0};
        in_same_b   = v.sb;
        in_same_c   = v.sc;
        in_same_h   = v.sh;
    endtask

    task automatic drive_simple(input int k);
        vec_t v;
        v = '{2'b01, 26'(k * 32'h1000 + 32'h4), 26'(k * 32'h1000), 26'h4,
              26'h0, 26'h0, 26'h0, 2'b00, 2'b00, 2'b01,
              2'b01, 1'b0, 1'b0, 26'h0, 1'b0};
        drive_vec(v);
    endtask

    vec_t vt [10];

    initial begin
        vt[0] = '{2'b01, 26'h120, 26'h100, 26'h20, 26'h0, 26'h0, 26'h0,
                  2'b00, 2'b00, 2'b01, 2'b01, 1'b0, 1'b0, 26'h120, 1'b0};
        vt[1] = '{2'b01, 26'h10, 26'h3FFFFF0, 26'h20, 26'h0, 26'h0, 26'h0,
                  2'b00, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 26'h10, 1'b1};
        vt[2] = '{2'b01, 26'h10, 26'h3FFFFF0, 26'h20, 26'h0, 26'h0, 26'h0,
                  2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 26'h10, 1'b1};
        vt[3] = '{2'b01, 26'h3FFFFF0, 26'h10, 26'h3FFFFE0, 26'h0, 26'h0, 26'h0,
                  2'b01, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 26'h3FFFFF0, 1'b0};
        vt[4] = '{2'b11, 26'h124, 26'h100, 26'h20, 26'h0, 26'h200, 26'h10,
                  2'b00, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0, 26'h120, 1'b0};
        vt[5] = '{2'b11, 26'h120, 26'h100, 26'h20, 26'h214, 26'h200, 26'h10,
                  2'b00, 2'b00, 2'b11, 2'b01, 1'b1, 1'b1, 26'h210, 1'b0};
        vt[6] = '{2'b00, 26'h120, 26'h100, 26'h20, 26'h210, 26'h200, 26'h10,
                  2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 26'h120, 1'b0};
        vt[7] = '{2'b11, 26'h120, 26'h100, 26'h20, 26'h210, 26'h200, 26'h10,
                  2'b00, 2'b00, 2'b11, 2'b11, 1'b0, 1'b0, 26'h120, 1'b0};
        vt[8] = '{2'b01, 26'hE0, 26'h100, 26'h3FFFFE0, 26'h0, 26'h0, 26'h0,
                  2'b00, 2'b00, 2'b01, 2'b01, 1'b0, 1'b0, 26'hE0, 1'b1};
        vt[9] = '{2'b10, 26'h0, 26'h0, 26'h0, 26'h10, 26'h3FFFFF0, 26'h20,
                  2'b00, 2'b00, 2'b10, 2'b00, 1'b1, 1'b1, 26'h10, 1'b1};

        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive_vec(vt[6]);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_same", 32'(out_same), 32'h0);
        chk("rst_out_target", 32'(out_target), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);

        // Table: one bundle at a time, result expected two edges after acceptance.
        for (int i = 0; i < 10; i++) begin
            drive_vec(vt[i]);
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk($sformatf("v%0d_t1_valid", i), 32'(out_valid), 32'h0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'h1);
            chk($sformatf("v%0d_same", i), 32'(out_same), 32'(vt[i].e_same));
            chk($sformatf("v%0d_miss", i), 32'(out_miss), 32'(vt[i].e_miss));
            chk($sformatf("v%0d_idx", i), 32'(out_miss_idx), 32'(vt[i].e_idx));
            chk($sformatf("v%0d_target", i), 32'(out_target), 32'(vt[i].e_tgt));
            chk($sformatf("v%0d_carry", i), 32'(out_carry), 32'(vt[i].e_carry));
        end
        @(posedge clk); #1;
        chk("drain_valid", 32'(out_valid), 32'h0);

        // Backpressure: 4 bundles, downstream stalled for the first 4 cycles.
        begin
            int sent = 0;
            int recv = 0;
            bit stalled = 1'b0;
            logic [LO_W-1:0] hold_tgt = '0;
            bit acc;
            for (int c = 0; c < 40 && recv < 4; c++) begin
                out_ready = (c >= 4);
                in_valid  = (sent < 4);
                drive_simple(sent);
                @(negedge clk);
                if (c == 2 || c == 3) chk($sformatf("bp_in_ready_c%0d", c), 32'(in_ready), 32'h0);
                if (out_valid && !out_ready) begin
                    if (stalled) chk("bp_hold_target", 32'(out_target), 32'(hold_tgt));
                    hold_tgt = out_target;
                    stalled  = 1'b1;
                end else begin
                    stalled = 1'b0;
                end
                if (out_valid && out_ready) begin
                    chk($sformatf("bp_target%0d", recv), 32'(out_target), recv * 32'h1000 + 32'h4);
                    chk($sformatf("bp_same%0d", recv), 32'(out_same), 32'h1);
                    recv++;
                end
                acc = in_valid && in_ready;
                @(posedge clk); #1;
                if (acc) sent++;
            end
            in_valid = 1'b0;
            chk("bp_received", 32'(recv), 32'h4);
            repeat (2) begin
                @(negedge clk);
                chk("bp_no_dup", 32'(out_valid), 32'h0);
            end
            @(posedge clk); #1;
        end

        // Flush with two bundles in flight and downstream stalled.
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive_simple(k + 5);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        chk("fl_pre_valid", 32'(out_valid), 32'h1);
        flush = 1'b1;
        drive_simple(9);
        #1;
        chk("fl_in_ready", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl_out_valid", 32'(out_valid), 32'h0);
        begin
            int seen = 0;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk("fl_nothing_delivered", 32'(seen), 32'h0);
        end

        // Reset pulse with two bundles in flight and downstream stalled.
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive_simple(k + 7);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("rs_pre_valid", 32'(out_valid), 32'h1);
        resetn = 1'b0;
        #1;
        chk("rs_out_valid", 32'(out_valid), 32'h0);
        chk("rs_out_target", 32'(out_target), 32'h0);
        chk("rs_out_same", 32'(out_same), 32'h0);
        chk("rs_out_miss", 32'(out_miss), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("rs_in_ready", 32'(in_ready), 32'h1);
        begin
            int seen = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk("rs_nothing_delivered", 32'(seen), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
